// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction memory and queues
// returned words with their addresses for decode through a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              r15,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_pc_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;
  logic          unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  always_comb begin
    occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    imem_req    = !reset && !branch_taken && (occupancy < (CW+1)'(DEPTH));
    imem_addr   = fetch_pc_q;
    instr_valid = (count_q != '0);
    push        = inflight_q && !branch_taken;
    pop         = instr_valid && instr_ready;
    fifo_count  = count_q;

    instr    = '0;
    instr_pc = '0;
    if (instr_valid) begin
      instr    = instr_mem_q[rd_ptr_q];
      instr_pc = pc_mem_q[rd_ptr_q];
    end
    r15 = instr_pc + 32'd8;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = imem_req;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    // A redirect flushes the queue and drops the response arriving this cycle;
    // a pop in the same cycle has already been handed to decode.
    if (branch_taken) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    req_pc_q <= imem_addr;
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle-by-cycle vectors for instruction_fetch_unit, plus a second
// instance started near the top of the address space to cover PC/R15 wrap.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, instr_pc, r15;
  logic [2:0]  fifo_count;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        instr_valid2;
  logic [31:0] instr2, instr_pc2, r15_2;
  logic [2:0]  fifo_count2;
  logic        br2 = 1'b0;
  logic        rdy2 = 1'b1;
  logic [31:0] tgt2 = 32'h0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .r15(r15), .fifo_count(fifo_count)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .branch_taken(br2), .branch_target(tgt2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .instr_valid(instr_valid2), .instr_ready(rdy2), .instr(instr2),
    .instr_pc(instr_pc2), .r15(r15_2), .fifo_count(fifo_count2)
  );

  // Memory model: word = addr | E000_0000, returned one cycle after a request;
  // junk otherwise so that a push without a request is visible.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  | 32'hE000_0000) : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_req2 ? (imem_addr2 | 32'hE000_0000) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic rdy, logic br, logic [31:0] tgt,
                              logic req, logic [31:0] addr, logic vld,
                              logic [31:0] pc, logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Checks one instance's outputs against an expected head; instr/r15 follow from pc.
  task automatic chk_out(input string tag, input int cyc,
                         input logic req_a, input logic [31:0] addr_a, input logic vld_a,
                         input logic [31:0] pc_a, input logic [31:0] ins_a,
                         input logic [31:0] r15_a, input logic [2:0] cnt_a,
                         input logic req_e, input logic [31:0] addr_e, input logic vld_e,
                         input logic [31:0] pc_e, input logic [2:0] cnt_e);
    logic [31:0] pc_x, ins_x;
    pc_x  = vld_e ? pc_e : 32'h0;
    ins_x = vld_e ? (pc_e | 32'hE000_0000) : 32'h0;
    chk({tag, "imem_req"},    cyc, {31'b0, req_a}, {31'b0, req_e});
    chk({tag, "imem_addr"},   cyc, addr_a, addr_e);
    chk({tag, "instr_valid"}, cyc, {31'b0, vld_a}, {31'b0, vld_e});
    chk({tag, "instr_pc"},    cyc, pc_a, pc_x);
    chk({tag, "instr"},       cyc, ins_a, ins_x);
    chk({tag, "r15"},         cyc, r15_a, pc_x + 32'd8);
    chk({tag, "fifo_count"},  cyc, {29'b0, cnt_a}, {29'b0, cnt_e});
  endtask

  initial begin
    logic [31:0] wrap_addr [4];
    logic [31:0] wrap_pc   [4];
    logic        wrap_vld  [4];
    wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    wrap_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    wrap_vld  = '{1'b0, 1'b0, 1'b1, 1'b1};

    //            rst rdy br tgt           req addr          vld pc            cnt
    // stall from reset: fill to 4, issue stops, head holds PC 0
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h00, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h04, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h08, 1, 32'h00, 3'd1));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h0C, 1, 32'h00, 3'd2));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 32'h10, 1, 32'h00, 3'd3));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 32'h10, 1, 32'h00, 3'd4));
    // resume: PCs pop in order, one per cycle
    tbl.push_back(mk(0, 1, 0, 32'h0,   0, 32'h10, 1, 32'h00, 3'd4));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h10, 1, 32'h04, 3'd3));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h14, 1, 32'h08, 3'd2));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h18, 1, 32'h0C, 3'd2));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h1C, 1, 32'h10, 3'd2));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h20, 1, 32'h14, 3'd2));
    // stall to three entries, then branch to 0x103 (aligned to 0x100)
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h24, 1, 32'h18, 3'd2));
    tbl.push_back(mk(0, 0, 1, 32'h103, 0, 32'h28, 1, 32'h18, 3'd3));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0, 3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0, 3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100, 3'd1));
    // branch with a pop of 0x104, then branch with a pop of 0x20
    tbl.push_back(mk(0, 1, 1, 32'h18,  0, 32'h10C, 1, 32'h104, 3'd1));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h18, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h1C, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h20, 1, 32'h18, 3'd1));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h24, 1, 32'h1C, 3'd1));
    tbl.push_back(mk(0, 1, 1, 32'h40,  0, 32'h28, 1, 32'h20, 3'd1));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h40, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h44, 0, 32'h0,  3'd0));
    // back-to-back branches: 0x300 wins
    tbl.push_back(mk(0, 1, 1, 32'h200, 0, 32'h48, 1, 32'h40, 3'd1));
    tbl.push_back(mk(0, 1, 1, 32'h300, 0, 32'h200, 0, 32'h0, 3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h300, 0, 32'h0, 3'd0));
    tbl.push_back(mk(0, 1, 0, 32'h0,   1, 32'h304, 0, 32'h0, 3'd0));
    // fill to 3 + one in flight, then reset together with a branch
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h308, 1, 32'h300, 3'd1));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h30C, 1, 32'h300, 3'd2));
    tbl.push_back(mk(1, 0, 1, 32'h500, 0, 32'h310, 1, 32'h300, 3'd3));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h00, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h04, 0, 32'h0,  3'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 32'h08, 1, 32'h00, 3'd1));

    reset = 1'b1; branch_taken = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   -1, {31'b0, imem_req}, 32'h0);
    chk("rst_valid", -1, {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", -1, instr, 32'h0);
    chk("rst_pc",    -1, instr_pc, 32'h0);
    chk("rst_r15",   -1, r15, 32'h8);
    chk("rst_count", -1, {29'b0, fifo_count}, 32'h0);
    chk("rst_r15_2", -1, r15_2, 32'h8);

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset         = tbl[i].rst;
      instr_ready   = tbl[i].rdy;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].tgt;
      @(negedge clk);
      chk_out("", i, imem_req, imem_addr, instr_valid, instr_pc, instr, r15, fifo_count,
              tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].cnt);
      if (i < 4)
        chk_out("wrap_", i, imem_req2, imem_addr2, instr_valid2, instr_pc2, instr2, r15_2,
                fifo_count2, 1'b1, wrap_addr[i], wrap_vld[i], wrap_pc[i],
                wrap_vld[i] ? 3'd1 : 3'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
